// File: rtl/arq_link_arbiter.sv
// Shares one link between ARQ data and coalesced cumulative acks.
// Registered output stage; data bursts are capped so a pending ack cannot starve.
module arq_link_arbiter #(
    parameter int DATA_W         = 16,
    parameter int ACK_W          = 8,
    parameter int MAX_DATA_BURST = 4,
    localparam int LINK_W        = (DATA_W > ACK_W) ? DATA_W : ACK_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [DATA_W-1:0] data_payload,
    input  logic              ack_trigger,
    input  logic [ACK_W-1:0]  ack_p,
    output logic              ack_did_trigger,
    output logic              link_valid,
    input  logic              link_ready,
    output logic              link_is_ack,
    output logic [LINK_W-1:0] link_payload
);

    localparam int CNT_W = $clog2(MAX_DATA_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_DATA_BURST);

    logic             ack_pend;
    logic [ACK_W-1:0] ack_val;
    logic [CNT_W-1:0] burst_cnt;

    logic load_en;
    logic burst_full;
    logic grant_data;
    logic grant_ack;
    logic take_data;
    logic take_ack;

    // Data wins unless an ack has already waited through a full burst.
    always_comb begin
        load_en    = !link_valid || link_ready;
        burst_full = ack_pend && (burst_cnt == BURST_MAX);
        grant_data = data_valid && !burst_full;
        grant_ack  = ack_pend && (!data_valid || burst_full);
        take_data  = load_en && grant_data;
        take_ack   = load_en && grant_ack;
    end

    assign data_ready      = !rst && take_data;
    assign ack_did_trigger = !rst && take_ack;

    // A new trigger always overwrites the stored ack, even in its grant cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_pend <= 1'b0;
            ack_val  <= '0;
        end else if (ack_trigger) begin
            ack_pend <= 1'b1;
            ack_val  <= ack_p;
        end else if (take_ack) begin
            ack_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt <= '0;
        end else if (!ack_pend || take_ack) begin
            burst_cnt <= '0;
        end else if (take_data && burst_cnt != BURST_MAX) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

    // Output register; it only changes when empty or being drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_valid   <= 1'b0;
            link_is_ack  <= 1'b0;
            link_payload <= '0;
        end else if (load_en) begin
            if (grant_data) begin
                link_valid   <= 1'b1;
                link_is_ack  <= 1'b0;
                link_payload <= LINK_W'(data_payload);
            end else if (grant_ack) begin
                link_valid   <= 1'b1;
                link_is_ack  <= 1'b1;
                link_payload <= LINK_W'(ack_val);
            end else begin
                link_valid   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arq_link_arbiter.sv
// Directed bench for arq_link_arbiter: inputs change at the falling edge,
// outputs are checked 1 ns later so registered state reflects the prior rising edge.
module tb_arq_link_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_valid;
    logic        data_ready;
    logic [15:0] data_payload;
    logic        ack_trigger;
    logic [7:0]  ack_p;
    logic        ack_did_trigger;
    logic        link_valid;
    logic        link_ready;
    logic        link_is_ack;
    logic [15:0] link_payload;

    int n_checks = 0;
    int n_errors = 0;

    arq_link_arbiter #(
        .DATA_W(16),
        .ACK_W(8),
        .MAX_DATA_BURST(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .data_payload(data_payload),
        .ack_trigger(ack_trigger),
        .ack_p(ack_p),
        .ack_did_trigger(ack_did_trigger),
        .link_valid(link_valid),
        .link_ready(link_ready),
        .link_is_ack(link_is_ack),
        .link_payload(link_payload)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic dv, input logic [15:0] dp,
                                 input logic at, input logic [7:0] ap,
                                 input logic lr);
        @(negedge clk);
        data_valid   = dv;
        data_payload = dp;
        ack_trigger  = at;
        ack_p        = ap;
        link_ready   = lr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkLink(input string tag, input logic v, input logic is_ack,
                             input logic [15:0] payload);
        checkOutput({tag, "_valid"}, link_valid, v);
        checkOutput({tag, "_is_ack"}, link_is_ack, is_ack);
        checkOutput({tag, "_payload"}, link_payload, payload);
    endtask

    initial begin
        rst          = 1'b1;
        data_valid   = 1'b1;
        data_payload = 16'h00FF;
        ack_trigger  = 1'b0;
        ack_p        = 8'h00;
        link_ready   = 1'b1;

        // Reset values, with data offered while reset is held.
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_data_ready", data_ready, 0);
        checkOutput("rst_ack_did", ack_did_trigger, 0);
        checkLink("rst_link", 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        rst        = 1'b0;
        data_valid = 1'b0;

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
            checkOutput("idle_valid", link_valid, 0);
        end

        // Eight back-to-back data words, one cycle of latency.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 16'(i + 1), 1'b0, 8'h00, 1'b1);
            checkOutput("seq_ready", data_ready, 1);
            checkOutput("seq_valid", link_valid, 32'(i > 0));
            if (i > 0) begin
                checkOutput("seq_payload", link_payload, i);
                checkOutput("seq_is_ack", link_is_ack, 0);
            end
        end
        applyStimulus(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
        checkLink("seq_last", 1'b1, 1'b0, 16'h0008);
        applyStimulus(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
        checkOutput("seq_drain", link_valid, 0);

        // Stalled link: two triggers coalesce into a single ack of 0x05.
        applyStimulus(1'b1, 16'h0AAA, 1'b0, 8'h00, 1'b0);
        checkOutput("coal_load_ready", data_ready, 1);
        applyStimulus(1'b0, 16'h0000, 1'b1, 8'h03, 1'b0);
        checkOutput("coal_did0", ack_did_trigger, 0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
        checkOutput("coal_did1", ack_did_trigger, 0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 8'h05, 1'b0);
        checkOutput("coal_did2", ack_did_trigger, 0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
        checkLink("coal_data", 1'b1, 1'b0, 16'h0AAA);
        checkOutput("coal_did3", ack_did_trigger, 1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
        checkLink("coal_ack", 1'b1, 1'b1, 16'h0005);
        checkOutput("coal_did4", ack_did_trigger, 0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
        checkOutput("coal_drain", link_valid, 0);

        // Burst cap: after the ack becomes pending, four data words then the ack.
        applyStimulus(1'b1, 16'h0100, 1'b1, 8'h2A, 1'b1);
        checkOutput("cap_ready0", data_ready, 1);
        for (int i = 1; i < 5; i++) begin
            applyStimulus(1'b1, 16'(16'h0100 + i), 1'b0, 8'h00, 1'b1);
            checkOutput("cap_ready", data_ready, 1);
            checkOutput("cap_did", ack_did_trigger, 0);
            checkLink("cap_data", 1'b1, 1'b0, 16'(16'h0100 + i - 1));
        end
        applyStimulus(1'b1, 16'h0105, 1'b0, 8'h00, 1'b1);
        checkOutput("cap_cnt_full", dut.burst_cnt, 4);
        checkOutput("cap_stall_ready", data_ready, 0);
        checkOutput("cap_grant_did", ack_did_trigger, 1);
        checkLink("cap_data4", 1'b1, 1'b0, 16'h0104);
        applyStimulus(1'b1, 16'h0105, 1'b0, 8'h00, 1'b1);
        checkOutput("cap_resume_ready", data_ready, 1);
        checkOutput("cap_cnt_clear", dut.burst_cnt, 0);
        checkLink("cap_ack", 1'b1, 1'b1, 16'h002A);
        applyStimulus(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
        checkLink("cap_resume", 1'b1, 1'b0, 16'h0105);
        applyStimulus(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
        checkOutput("cap_drain", link_valid, 0);

        // Trigger in the grant cycle: old value goes out, new value follows.
        applyStimulus(1'b1, 16'h0BBB, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 8'h06, 1'b0);
        checkOutput("same_did0", ack_did_trigger, 0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 8'h07, 1'b1);
        checkOutput("same_did1", ack_did_trigger, 1);
        checkLink("same_data", 1'b1, 1'b0, 16'h0BBB);
        applyStimulus(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
        checkOutput("same_did2", ack_did_trigger, 1);
        checkLink("same_ack6", 1'b1, 1'b1, 16'h0006);
        applyStimulus(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
        checkOutput("same_did3", ack_did_trigger, 0);
        checkLink("same_ack7", 1'b1, 1'b1, 16'h0007);
        applyStimulus(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
        checkOutput("same_drain", link_valid, 0);

        // Backpressure holds the word, then reset drops it and the pending ack.
        applyStimulus(1'b1, 16'h1234, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'h5678, 1'b0, 8'h00, 1'b0);
            if (i == 0) ack_trigger = 1'b1;
            if (i == 0) ack_p = 8'h44;
            checkOutput("hold_ready", data_ready, 0);
            checkLink("hold_link", 1'b1, 1'b0, 16'h1234);
        end
        ack_trigger = 1'b0;
        checkOutput("hold_pend", dut.ack_pend, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", link_valid, 0);
        checkOutput("midrst_pend", dut.ack_pend, 0);
        checkOutput("midrst_ready", data_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 16'h9999, 1'b0, 8'h00, 1'b1);
        checkOutput("post_ready", data_ready, 1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
        checkLink("post_data", 1'b1, 1'b0, 16'h9999);
        applyStimulus(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
        checkOutput("post_drain", link_valid, 0);
        checkOutput("post_did", ack_did_trigger, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/arq_link_arbiter.md
# arq_link_arbiter

Shares one physical link between the ARQ sender's data stream and the ARQ receiver's cumulative acks. It sits between `arq_sender`/`arq_receiver` and the link, in place of the two separate `link_model` channels. Acks are coalesced so only the newest pending ack is ever sent. The output is a single registered stage with a type bit, and data bursts are capped so a pending ack is never starved.

## Interface
Parameters:
- DATA_W, 16: data payload width (seq + data).
- ACK_W, 8: ack payload width.
- MAX_DATA_BURST, 4: maximum consecutive data grants while an ack is pending (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous and active-high.
- data_valid  in  1  sender data valid.
- data_ready  out  1  sender data accepted this cycle.
- data_payload  in  DATA_W  sender data.
- ack_trigger  in  1  receiver requests that ack_p be sent.
- ack_p  in  ACK_W  cumulative ack value.
- ack_did_trigger  out  1  pulse: pending ack was loaded onto the link.
- link_valid  out  1  link word valid.
- link_ready  in  1  link accepts word.
- link_is_ack  out  1  1 = ack word, 0 = data word.
- link_payload  out  LINK_W  link word. LINK_W = max(DATA_W, ACK_W); the narrower source is zero-extended.

## Operation
- Ack holding register (ack_pend, ack_val):
  - When ack_trigger is high, ack_val <= ack_p and ack_pend <= 1.
  - A trigger while already pending overwrites ack_val (latest wins); there is no queue.
- load_en = !link_valid || link_ready.
- Grant, evaluated only when load_en:
  - Only data_valid: grant data.
  - Only ack_pend: grant ack.
  - Both, and burst_cnt < MAX_DATA_BURST: grant data.
  - Both, and burst_cnt == MAX_DATA_BURST: grant ack.
  - Neither: load_en loads link_valid <= 0.
- data_ready = load_en && grant_data. It is combinational from data_valid, ack_pend, burst_cnt, link_valid and link_ready, and has no dependency on data_payload.
- On a data grant:
  - Load link_payload with the zero-extended data_payload and set link_is_ack = 0.
  - If ack_pend, burst_cnt increments, saturating at MAX_DATA_BURST.
- On an ack grant:
  - Load link_payload with the zero-extended ack_val and set link_is_ack = 1.
  - ack_did_trigger = 1, ack_pend clears, burst_cnt <= 0.
- While !ack_pend, burst_cnt <= 0.
- Ack grant and ack_trigger in the same cycle:
  - The old ack_val goes onto the link.
  - The new value is stored and ack_pend stays 1.
- Ack grants use only the registered ack_val; there is no same-cycle bypass of ack_p.
- No traffic is generated when neither source has work: link_valid falls after the last word is accepted.

## Timing
- Reset values: link_valid=0, link_is_ack=0, link_payload=0, ack_pend=0, ack_val=0, burst_cnt=0, ack_did_trigger=0.
- data_ready is 0 during reset.
- Data latency: 1 cycle from data_valid && data_ready to link_valid.
- Ack latency:
  - 1 cycle to set ack_pend.
  - Earliest link_valid with the ack: 2 cycles after ack_trigger.
  - Worst case with continuous data and link_ready=1: MAX_DATA_BURST+2 cycles.
- Throughput: one word per cycle while link_ready=1.
- Output stability: while link_valid && !link_ready, link_valid, link_is_ack and link_payload hold stable, and data_ready=0.
- ack_did_trigger is a one-cycle pulse, coincident with the grant cycle.
- Reset asserted mid-operation:
  - All state clears immediately (asynchronously).
  - The in-flight link word and the pending ack are dropped; ARQ retransmission recovers them.

## Test plan
- Reset, then idle with no inputs -> link_valid=0 for 20 cycles; data_ready=0 while rst=1.
- Data 0x0001..0x0008 back-to-back with link_ready=1 and no acks -> link carries 8 data words on consecutive cycles, starting 1 cycle after the first accept, all link_is_ack=0.
- link_ready=0, ack_trigger with 0x03, then 0x05 two cycles later, then link_ready=1 -> exactly one ack word (0x05, link_is_ack=1); one ack_did_trigger pulse.
- MAX_DATA_BURST=4, continuous data, ack_trigger 0x2A once -> exactly 4 data words, then ack 0x2A, then data resumes; burst_cnt returns to 0.
- Ack grant cycle with a simultaneous ack_trigger 0x07 while 0x06 is pending -> link sends 0x06; a second ack 0x07 follows; two ack_did_trigger pulses total.
- Hold link_ready=0 for 5 cycles with a data word loaded -> link_payload stable and data_ready=0; then assert rst mid-stream -> link_valid=0 and ack_pend=0 the same cycle; resumes cleanly after release.
